// File: rtl/converge_stream_if.sv
// Stream/control bundle for converge_stream: evaluation control, the
// entry stream with its handshake, and the result/status outputs.
interface converge_stream_if #(
    parameter int WIDTH      = 16,
    parameter int FRACT      = 8,
    parameter int N_STOCKS   = 4,
    parameter int MAX_SWEEPS = 16
);
    localparam int ACC_W   = 2 * WIDTH + $clog2(N_STOCKS * N_STOCKS);
    localparam int SUM_W   = ACC_W - FRACT;
    localparam int SWEEP_W = $clog2(MAX_SWEEPS + 1);

    logic               start_in;
    logic               clear_sweeps_in;
    logic [WIDTH-1:0]   threshold_in;
    logic [WIDTH-1:0]   entry_in;
    logic               entry_valid_in;
    logic               entry_ready_out;
    logic               busy_out;
    logic               done_out;
    logic               conv_out;
    logic               timeout_out;
    logic [SUM_W-1:0]   sum_out;
    logic [SWEEP_W-1:0] sweep_count_out;

    modport master (
        output start_in, clear_sweeps_in, threshold_in, entry_in, entry_valid_in,
        input  entry_ready_out, busy_out, done_out, conv_out, timeout_out,
               sum_out, sweep_count_out
    );

    modport slave (
        input  start_in, clear_sweeps_in, threshold_in, entry_in, entry_valid_in,
        output entry_ready_out, busy_out, done_out, conv_out, timeout_out,
               sum_out, sweep_count_out
    );
endinterface

// File: rtl/converge_stream.sv
// Streaming off-diagonal convergence check for the Jacobi eigen-solver.
// Entries arrive row-major, are squared in a one-stage pipeline, and the
// off-diagonal squares are summed. The scaled sum is compared against a
// latched threshold; non-converged evaluations are counted up to a timeout.
// MAX_SWEEPS must be at least 1.
module converge_stream #(
    parameter int WIDTH      = 16,
    parameter int FRACT      = 8,
    parameter int N_STOCKS   = 4,
    parameter int MAX_SWEEPS = 16
) (
    input  logic            clk_in,
    input  logic            rst_in,
    converge_stream_if.slave bus
);
    localparam int ACC_W   = 2 * WIDTH + $clog2(N_STOCKS * N_STOCKS);
    localparam int SUM_W   = ACC_W - FRACT;
    localparam int SWEEP_W = $clog2(MAX_SWEEPS + 1);
    localparam int RC_W    = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
    localparam logic [RC_W-1:0]    LAST_IDX  = RC_W'(N_STOCKS - 1);
    localparam logic [SWEEP_W-1:0] SWEEP_MAX = SWEEP_W'(MAX_SWEEPS);

    typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, COMPARE, DONE} state_t;

    state_t                    state_reg, state_next;
    logic [RC_W-1:0]           row_reg, col_reg;
    logic [2*WIDTH-1:0]        sq_reg;
    logic                      sq_add_reg;
    logic [ACC_W-1:0]          acc_reg;
    logic [WIDTH-1:0]          thresh_reg;
    logic [SUM_W-1:0]          sum_reg;
    logic                      conv_reg, done_reg, timeout_reg;
    logic [SWEEP_W-1:0]        sweep_reg;

    logic                      entry_ready, busy;
    logic                      start_ok, accept, last_entry, off_diag;
    logic signed [2*WIDTH-1:0] entry_ext, square;
    logic [SUM_W-1:0]          sum_next;
    logic                      conv_next;
    logic [SWEEP_W-1:0]        sweep_inc;

    // Start is honoured only while no evaluation is in flight.
    assign start_ok   = bus.start_in && (state_reg == IDLE || state_reg == DONE);
    assign accept     = bus.entry_valid_in && entry_ready;
    assign last_entry = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);
    assign off_diag   = (row_reg != col_reg);

    // Sign-extend before multiplying so the full-width product is exact.
    assign entry_ext  = {{WIDTH{bus.entry_in[WIDTH-1]}}, bus.entry_in};
    assign square     = entry_ext * entry_ext;

    // Scaled sum and threshold test, both evaluated in COMPARE.
    assign sum_next   = SUM_W'(acc_reg >> FRACT);
    assign conv_next  = (sum_next < SUM_W'(thresh_reg));
    assign sweep_inc  = (sweep_reg == SWEEP_MAX) ? sweep_reg : sweep_reg + 1'b1;

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = ACCUM;
            ACCUM:   if (accept && last_entry) state_next = FLUSH;
            FLUSH:   state_next = COMPARE;
            COMPARE: state_next = DONE;
            DONE:    if (start_ok) state_next = ACCUM;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        entry_ready = 1'b0;
        busy        = 1'b0;
        case (state_reg)
            ACCUM:   begin entry_ready = 1'b1; busy = 1'b1; end
            FLUSH:   busy = 1'b1;
            COMPARE: busy = 1'b1;
            default: ;
        endcase
    end

    // Row/column position of the next expected entry; stalls on gaps.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (start_ok) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (accept) begin
            if (col_reg == LAST_IDX) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    // Squarer stage: only accepted off-diagonal entries are marked for summing.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sq_reg     <= '0;
            sq_add_reg <= 1'b0;
        end else begin
            if (accept) sq_reg <= square;
            sq_add_reg <= accept && off_diag;
        end
    end

    // Accumulator: squares are non-negative so zero-extension is exact.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)          acc_reg <= '0;
        else if (start_ok)   acc_reg <= '0;
        else if (sq_add_reg) acc_reg <= acc_reg + ACC_W'(sq_reg);
    end

    // Result registers: threshold latched on start, result captured in COMPARE.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            thresh_reg <= '0;
            sum_reg    <= '0;
            conv_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= (state_reg == COMPARE);
            if (start_ok) begin
                thresh_reg <= bus.threshold_in;
                conv_reg   <= 1'b0;
            end else if (state_reg == COMPARE) begin
                sum_reg  <= sum_next;
                conv_reg <= conv_next;
            end
        end
    end

    // Sweep counter and timeout; an explicit clear overrides a COMPARE increment.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sweep_reg   <= '0;
            timeout_reg <= 1'b0;
        end else if (bus.clear_sweeps_in) begin
            sweep_reg   <= '0;
            timeout_reg <= 1'b0;
        end else if (state_reg == COMPARE && !conv_next) begin
            sweep_reg <= sweep_inc;
            if (sweep_inc == SWEEP_MAX) timeout_reg <= 1'b1;
        end
    end

    assign bus.entry_ready_out = entry_ready;
    assign bus.busy_out        = busy;
    assign bus.done_out        = done_reg;
    assign bus.conv_out        = conv_reg;
    assign bus.timeout_out     = timeout_reg;
    assign bus.sum_out         = sum_reg;
    assign bus.sweep_count_out = sweep_reg;
endmodule

// File: tb/tb_converge_stream.sv
// Scoreboard bench for converge_stream: expected results are queued when a
// matrix is driven and compared when the block pulses done.
module tb_converge_stream;
    localparam int WIDTH      = 16;
    localparam int FRACT      = 8;
    localparam int N_STOCKS   = 4;
    localparam int MAX_SWEEPS = 3;
    localparam int ACC_W      = 2 * WIDTH + $clog2(N_STOCKS * N_STOCKS);
    localparam int SUM_W      = ACC_W - FRACT;
    localparam int SWEEP_W    = $clog2(MAX_SWEEPS + 1);

    typedef struct {
        logic [SUM_W-1:0]   sum;
        logic               conv;
        logic [SWEEP_W-1:0] sweep;
        logic               timeout;
        int                 start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_txn = 0;
    int   m_sweep = 0;
    logic m_timeout = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    converge_stream_if #(.WIDTH(WIDTH), .FRACT(FRACT), .N_STOCKS(N_STOCKS),
                         .MAX_SWEEPS(MAX_SWEEPS)) bus ();

    converge_stream #(.WIDTH(WIDTH), .FRACT(FRACT), .N_STOCKS(N_STOCKS),
                      .MAX_SWEEPS(MAX_SWEEPS)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one full matrix (diagonal value diag, every off-diagonal value offd).
    task automatic run_matrix(input logic [15:0] diag, input logic [15:0] offd,
                              input logic [15:0] thr, input bit gaps,
                              input bit start_mid, input bit clr_cmp);
        exp_t   e;
        longint s;
        int     sv;
        int     k;
        bit     got;
        s  = 0;
        sv = $signed(offd);
        s  = longint'(N_STOCKS * (N_STOCKS - 1)) * longint'(sv) * longint'(sv);
        e.sum  = SUM_W'(s >> FRACT);
        e.conv = ((s >> FRACT) < longint'(thr));
        if (!e.conv) begin
            if (m_sweep < MAX_SWEEPS) m_sweep++;
            if (m_sweep == MAX_SWEEPS) m_timeout = 1'b1;
        end
        if (clr_cmp) begin
            m_sweep   = 0;
            m_timeout = 1'b0;
        end
        e.sweep   = SWEEP_W'(m_sweep);
        e.timeout = m_timeout;

        @(posedge clk); #1;
        bus.start_in     = 1'b1;
        bus.threshold_in = thr;
        k = cyc;
        e.start_cyc = gaps ? -1 : k;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        for (int i = 0; i < N_STOCKS * N_STOCKS; i++) begin
            bus.entry_in       = (i / N_STOCKS == i % N_STOCKS) ? diag : offd;
            bus.entry_valid_in = 1'b1;
            if (i == 0) begin
                check_eq("ready_accum", bus.entry_ready_out, 1);
                check_eq("busy_accum", bus.busy_out, 1);
            end
            @(posedge clk); #1;
            if (gaps) begin
                bus.entry_valid_in = 1'b0;
                bus.entry_in       = 16'h7777;
                bus.start_in       = start_mid && (i == 5);
                bus.threshold_in   = start_mid ? 16'h0000 : thr;
                @(posedge clk); #1;
                bus.start_in = 1'b0;
            end
        end
        bus.entry_valid_in = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            bus.clear_sweeps_in = clr_cmp && (cyc == k + 18);
            @(negedge clk);
            check_eq("ready_low", bus.entry_ready_out, 0);
            if (bus.done_out) got = 1'b1;
            @(posedge clk); #1;
        end
        bus.clear_sweeps_in = 1'b0;
        if (!got) check_eq("done_seen", got, 1);
        @(negedge clk);
        check_eq("done_pulse", bus.done_out, 0);
        check_eq("busy_done", bus.busy_out, 0);
    endtask

    // Scoreboard consumer: compare every done pulse against the queue head.
    always @(negedge clk) begin
        if (!rst && bus.done_out) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", bus.done_out, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("sum", bus.sum_out, mon_e.sum);
                check_eq("conv", bus.conv_out, mon_e.conv);
                check_eq("sweeps", bus.sweep_count_out, mon_e.sweep);
                check_eq("timeout", bus.timeout_out, mon_e.timeout);
                check_eq("busy_at_done", bus.busy_out, 0);
                if (mon_e.start_cyc >= 0) check_eq("latency", cyc - mon_e.start_cyc, 19);
                $display("txn %0d: sum=0x%0h conv=%0b sweeps=%0d timeout=%0b cycle=%0d",
                         n_txn, bus.sum_out, bus.conv_out, bus.sweep_count_out,
                         bus.timeout_out, cyc);
                n_txn++;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_in        = 1'b0;
        bus.clear_sweeps_in = 1'b0;
        bus.threshold_in    = '0;
        bus.entry_in        = '0;
        bus.entry_valid_in  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", bus.entry_ready_out, 0);
        check_eq("rst_busy", bus.busy_out, 0);
        check_eq("rst_done", bus.done_out, 0);
        check_eq("rst_conv", bus.conv_out, 0);
        check_eq("rst_timeout", bus.timeout_out, 0);
        check_eq("rst_sum", bus.sum_out, 0);
        check_eq("rst_sweeps", bus.sweep_count_out, 0);
        rst = 1'b0;

        // Identity matrix converges.
        run_matrix(16'h0100, 16'h0000, 16'h0400, 0, 0, 0);
        // Off-diagonal +1.0 and -1.0 give the same non-converged sum.
        run_matrix(16'h7FFF, 16'h0100, 16'h0400, 0, 0, 0);
        run_matrix(16'h7FFF, 16'hFF00, 16'h0400, 0, 0, 0);
        // Worst-case magnitudes; third miss reaches the timeout.
        run_matrix(16'h8000, 16'h8000, 16'h0400, 0, 0, 0);
        // Gapped stream with a start pulse mid-matrix; counter saturates.
        run_matrix(16'h7FFF, 16'h0100, 16'h0400, 1, 1, 0);
        // Converged evaluation leaves the saturated count untouched.
        run_matrix(16'h0100, 16'h0000, 16'h0400, 0, 0, 0);
        // Threshold boundary: strict less-than.
        run_matrix(16'h7FFF, 16'h0100, 16'h0C00, 0, 0, 0);
        run_matrix(16'h7FFF, 16'h0100, 16'h0C01, 0, 0, 0);

        // Standalone clear while in DONE.
        @(posedge clk); #1;
        bus.clear_sweeps_in = 1'b1;
        m_sweep   = 0;
        m_timeout = 1'b0;
        @(posedge clk); #1;
        bus.clear_sweeps_in = 1'b0;
        @(negedge clk);
        check_eq("clear_sweeps", bus.sweep_count_out, 0);
        check_eq("clear_timeout", bus.timeout_out, 0);
        check_eq("conv_held", bus.conv_out, 1);

        // Clear coinciding with a COMPARE increment wins.
        run_matrix(16'h7FFF, 16'h0100, 16'h0400, 0, 0, 1);

        // Reset in the middle of a matrix.
        @(posedge clk); #1;
        bus.start_in     = 1'b1;
        bus.threshold_in = 16'h0400;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.entry_in       = 16'h0100;
            bus.entry_valid_in = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.entry_valid_in = 1'b0;
        m_sweep   = 0;
        m_timeout = 1'b0;
        #1;
        check_eq("midrst_busy", bus.busy_out, 0);
        check_eq("midrst_ready", bus.entry_ready_out, 0);
        check_eq("midrst_sum", bus.sum_out, 0);
        check_eq("midrst_conv", bus.conv_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_matrix(16'h0100, 16'h0000, 16'h0400, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
